// File: rtl/my_parity_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : my_parity_rx_if
//  Description : Serial-line and result bundle for the parity frame receiver.
//                err_count exists only with MY_PARITY_RX_ERRCNT_EN defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface my_parity_rx_if #(
    parameter int DATA_W = 8
);
    logic              bit_en;
    logic              rxd;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;
`ifdef MY_PARITY_RX_ERRCNT_EN
    logic [7:0]        err_count;
`endif

    modport master (
        output bit_en,
        output rxd,
        input  data_out,
        input  valid,
        input  parity_err,
        input  frame_err,
`ifdef MY_PARITY_RX_ERRCNT_EN
        input  err_count,
`endif
        input  busy
    );

    modport slave (
        input  bit_en,
        input  rxd,
        output data_out,
        output valid,
        output parity_err,
        output frame_err,
`ifdef MY_PARITY_RX_ERRCNT_EN
        output err_count,
`endif
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/my_parity_rx.sv
`default_nettype none
// ============================================================================
//  Module      : my_parity_rx
//  Description : Receives start / DATA_W data (LSB first) / even parity / stop
//                frames; flags parity and framing errors. Optional saturating
//                error counter under MY_PARITY_RX_ERRCNT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module my_parity_rx #(
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    my_parity_rx_if.slave bus
);
    localparam int                CNT_W  = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] w_shreg_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_acc;
    logic              r_perr;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_parity_err;
    logic              r_frame_err;

    // New bits enter at the MSB so the first (LSB) bit ends up at bit 0.
    generate
        if (DATA_W > 1) begin : g_shift_multi
            assign w_shreg_next = {bus.rxd, r_shreg[DATA_W-1:1]};
        end else begin : g_shift_single
            assign w_shreg_next = bus.rxd;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.bit_en) begin
            case (r_state)
                S_IDLE:   if (!bus.rxd) w_state_next = S_DATA;
                S_DATA:   if (r_cnt == C_LAST) w_state_next = S_PARITY;
                S_PARITY: w_state_next = S_STOP;
                S_STOP:   w_state_next = S_IDLE;
                default:  w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_acc        <= 1'b0;
            r_perr       <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            if (bus.bit_en) begin
                case (r_state)
                    S_IDLE: begin
                        if (!bus.rxd) begin
                            r_cnt <= '0;
                            r_acc <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        r_shreg <= w_shreg_next;
                        r_acc   <= r_acc ^ bus.rxd;
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                    S_PARITY: begin
                        r_perr <= r_acc ^ bus.rxd;
                    end
                    S_STOP: begin
                        if (bus.rxd) begin
                            r_data       <= r_shreg;
                            r_parity_err <= r_perr;
                            r_valid      <= 1'b1;
                        end else begin
                            r_frame_err  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef MY_PARITY_RX_ERRCNT_EN
    logic [7:0] r_err_count;
    logic       w_err_evt;

    // Counts on the same edge that raises a flagged valid or a frame_err pulse.
    assign w_err_evt = bus.bit_en && (r_state == S_STOP) && (!bus.rxd || r_perr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= 8'd0;
        end else if (w_err_evt && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign bus.err_count = r_err_count;
`endif

    assign bus.data_out   = r_data;
    assign bus.valid      = r_valid;
    assign bus.parity_err = r_parity_err;
    assign bus.frame_err  = r_frame_err;
    assign bus.busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_my_parity_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_my_parity_rx
//  Description : Directed frames against a frame-level model of the receiver.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_my_parity_rx;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    my_parity_rx_if #(.DATA_W(DATA_W)) bus ();

    my_parity_rx #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Frame-level model: collect sampled bits after a start, judge the frame whole.
    bit              q_bits[$];
    bit              m_collect = 1'b0;
    logic [7:0]      m_data    = 8'h00;
    logic            m_perr    = 1'b0;
    logic            m_valid   = 1'b0;
    logic            m_ferr    = 1'b0;
    int              m_errs    = 0;
    int              valid_seen = 0;
    int              gap_idx   = 0;

    task automatic model_clear();
        q_bits.delete();
        m_collect = 1'b0;
        m_data    = 8'h00;
        m_perr    = 1'b0;
        m_valid   = 1'b0;
        m_ferr    = 1'b0;
        m_errs    = 0;
    endtask

    task automatic model_step(input logic en, input logic b);
        int ones;
        logic [7:0] d;
        m_valid = 1'b0;
        m_ferr  = 1'b0;
        if (!en) return;
        if (!m_collect) begin
            if (b == 1'b0) begin
                m_collect = 1'b1;
                q_bits.delete();
            end
        end else begin
            q_bits.push_back(b);
            if (q_bits.size() == DATA_W + 2) begin
                ones = 0;
                d    = 8'h00;
                for (int i = 0; i <= DATA_W; i++) ones += int'(q_bits[i]);
                for (int i = 0; i < DATA_W; i++) d += 8'(int'(q_bits[i]) << i);
                if (q_bits[DATA_W+1]) begin
                    m_valid = 1'b1;
                    m_data  = d;
                    m_perr  = (ones % 2) != 0;
                    if (m_perr && m_errs < 255) m_errs++;
                end else begin
                    m_ferr = 1'b1;
                    if (m_errs < 255) m_errs++;
                end
                m_collect = 1'b0;
            end
        end
    endtask

    task automatic tick(input logic en, input logic b);
        bus.bit_en = en;
        bus.rxd    = b;
        @(posedge clk);
        if (!rst) model_step(en, b);
        #1;
    endtask

    task automatic send_bit(input logic b, input int mode);
        int gap;
        case (mode)
            0:       gap = 3;
            1:       begin gap = (gap_idx * 5 + 1) % 9 + 1; gap_idx++; end
            default: gap = 0;
        endcase
        repeat (gap) tick(1'b0, b);
        tick(1'b1, b);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int mode);
        send_bit(1'b0, mode);
        for (int i = 0; i < DATA_W; i++) send_bit(d[i], mode);
        send_bit(p, mode);
        send_bit(s, mode);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b1);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic ok;
        ok = (bus.valid === m_valid) && (bus.frame_err === m_ferr) &&
             (bus.data_out === m_data) && (bus.parity_err === m_perr) &&
             (bus.busy === m_collect);
`ifdef MY_PARITY_RX_ERRCNT_EN
        ok = ok && (bus.err_count === 8'(m_errs));
`endif
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL cycle @%0t: got v=%b fe=%b d=%h pe=%b busy=%b expected v=%b fe=%b d=%h pe=%b busy=%b",
                     $time, bus.valid, bus.frame_err, bus.data_out, bus.parity_err, bus.busy,
                     m_valid, m_ferr, m_data, m_perr, m_collect);
        end
        if (bus.valid === 1'b1) valid_seen++;
    end

    initial begin
        bus.bit_en = 1'b0;
        bus.rxd    = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", 32'(bus.data_out), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;
        idle(4);

        // Good frame 0xA5, even parity bit 0
        send_frame(8'hA5, 1'b0, 1'b1, 0);
        idle(3);
        check("t1_data", 32'(bus.data_out), 32'hA5);
        check("t1_perr", 32'(bus.parity_err), 32'h0);

        // Wrong parity bit
        send_frame(8'hA5, 1'b1, 1'b1, 0);
        idle(3);
        check("t2_perr", 32'(bus.parity_err), 32'h1);

        // Framing error: data_out holds 0xA5
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        idle(3);
        check("t3_data_hold", 32'(bus.data_out), 32'hA5);
        check("t3_perr_hold", 32'(bus.parity_err), 32'h1);

        // Reset mid-frame after three data bits of 0xFF
        send_bit(1'b0, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
        check("t4_busy_before", 32'(bus.busy), 32'h1);
        #1 rst = 1'b1;
        model_clear();
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        check("t4_busy", 32'(bus.busy), 32'h0);
        check("t4_data", 32'(bus.data_out), 32'h0);
        check("t4_perr", 32'(bus.parity_err), 32'h0);
        #1 rst = 1'b0;
        idle(4);
        send_frame(8'h3C, 1'b0, 1'b1, 0);
        idle(3);
        check("t4_next_data", 32'(bus.data_out), 32'h3C);
        check("t4_next_perr", 32'(bus.parity_err), 32'h0);

        // Irregular strobe gaps, back-to-back frames
        valid_seen = 0;
        send_frame(8'h01, 1'b1, 1'b1, 1);
        send_frame(8'h80, 1'b1, 1'b1, 1);
        idle(3);
        check("t5_pulses", 32'(valid_seen), 32'd2);
        check("t5_data", 32'(bus.data_out), 32'h80);
        check("t5_perr", 32'(bus.parity_err), 32'h0);

`ifdef MY_PARITY_RX_ERRCNT_EN
        check("t6_cnt0", 32'(bus.err_count), 32'd0);
        for (int i = 0; i < 3; i++) send_frame(8'h5A, 1'b1, 1'b1, 0);
        idle(3);
        check("t6_cnt3", 32'(bus.err_count), 32'd3);
        for (int i = 0; i < 257; i++) send_frame(8'(i), ~(^8'(i)), 1'b1, 2);
        idle(3);
        check("t6_sat", 32'(bus.err_count), 32'd255);
`else
        send_frame(8'h5A, 1'b1, 1'b1, 2);
        idle(3);
        check("t6_perr", 32'(bus.parity_err), 32'h1);
        check("t6_data", 32'(bus.data_out), 32'h5A);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
